// File: rtl/tl_sched_pkg.sv
// Shared light codes and phase-state encoding for the traffic-light scheduler.
package tl_sched_pkg;

  localparam int unsigned ST_W = 3;

  typedef enum logic [1:0] {
    GREEN  = 2'b00,
    YELLOW = 2'b01,
    RED    = 2'b10
  } light_e;

  typedef enum logic [ST_W-1:0] {
    A_GRN = 3'd0,
    A_YEL = 3'd1,
    AR_AB = 3'd2,
    B_GRN = 3'd3,
    B_YEL = 3'd4,
    AR_BA = 3'd5
  } state_e;

endpackage

// File: rtl/tl_phase_timer.sv
// Phase dwell timer: synchronous clear, count enable, saturates at lim.
module tl_phase_timer #(
  parameter int unsigned TW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  input  logic [TW-1:0] lim,
  output logic [TW-1:0] cnt
);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  // Next count: clear wins, otherwise step while enabled and below the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q < lim)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/tl_phase_sched.sv
// Two-street traffic-light phase scheduler: green/yellow/all-red sequencing
// with minimum/maximum green, fixed yellow and all-red clearance.
module tl_phase_sched
  import tl_sched_pkg::*;
#(
  parameter int unsigned TW         = 5,
  parameter int unsigned MIN_GREEN  = 4,
  parameter int unsigned MAX_GREEN  = 12,
  parameter int unsigned YEL_CYC    = 3,
  parameter int unsigned ALLRED_CYC = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Ta,
  input  logic       Tb,
  input  logic       hold,
  output logic [1:0] La,
  output logic [1:0] Lb,
  output logic [2:0] phase,
  output logic       phase_chg
);

  localparam int unsigned TMAX = (2 ** TW) - 1;

  if ((MIN_GREEN < 1) || (MAX_GREEN < MIN_GREEN) || (YEL_CYC < 1) ||
      (ALLRED_CYC < 1) || (MIN_GREEN > TMAX) || (MAX_GREEN > TMAX) ||
      (YEL_CYC > TMAX) || (ALLRED_CYC > TMAX)) begin : g_bad_params
    $error("tl_phase_sched: illegal timing parameters");
  end

  localparam logic [TW-1:0] MIN_M1 = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_M1 = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] YEL_M1 = TW'(YEL_CYC - 1);
  localparam logic [TW-1:0] AR_M1  = TW'(ALLRED_CYC - 1);

  state_e        state_q;
  state_e        state_d;
  logic          phase_chg_q;
  logic          phase_chg_d;
  logic          tmr_clr;
  logic [TW-1:0] tmr_lim;
  logic [TW-1:0] timer;

  tl_phase_timer #(
    .TW (TW)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (tmr_clr),
    .en    (!hold),
    .lim   (tmr_lim),
    .cnt   (timer)
  );

  // Next-state logic; hold overrides any exit, and any change clears the timer.
  always_comb begin
    state_d = state_q;
    tmr_lim = MAX_M1;
    case (state_q)
      A_GRN: begin
        tmr_lim = MAX_M1;
        if ((timer >= MIN_M1) && Tb && (!Ta || (timer >= MAX_M1))) state_d = A_YEL;
      end
      A_YEL: begin
        tmr_lim = YEL_M1;
        if (timer == YEL_M1) state_d = AR_AB;
      end
      AR_AB: begin
        tmr_lim = AR_M1;
        if (timer == AR_M1) state_d = B_GRN;
      end
      B_GRN: begin
        tmr_lim = MAX_M1;
        if ((timer >= MIN_M1) && Ta && (!Tb || (timer >= MAX_M1))) state_d = B_YEL;
      end
      B_YEL: begin
        tmr_lim = YEL_M1;
        if (timer == YEL_M1) state_d = AR_BA;
      end
      AR_BA: begin
        tmr_lim = AR_M1;
        if (timer == AR_M1) state_d = A_GRN;
      end
      default: begin
        tmr_lim = '0;
        state_d = AR_BA;
      end
    endcase
    if (hold) state_d = state_q;
    tmr_clr     = (state_d != state_q);
    phase_chg_d = tmr_clr;
  end

  // State and phase-change flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= A_GRN;
      phase_chg_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_chg_q <= phase_chg_d;
    end
  end

  // Moore light decode from the state register only.
  always_comb begin
    La = RED;
    Lb = RED;
    case (state_q)
      A_GRN:   La = GREEN;
      A_YEL:   La = YELLOW;
      B_GRN:   Lb = GREEN;
      B_YEL:   Lb = YELLOW;
      default: begin
        La = RED;
        Lb = RED;
      end
    endcase
  end

  assign phase     = state_q;
  assign phase_chg = phase_chg_q;

endmodule

// File: doc/tl_phase_sched.md
Name: tl_phase_sched

Overview:
- Timed traffic-light phase scheduler for two crossing streets, A and B, which share one intersection.
- Sequences green, yellow and all-red phases from the traffic sensors Ta and Tb.
- Enforces a minimum green time, a maximum green time (only when the other side is waiting), a fixed yellow time and an all-red clearance interval.
- Drives the La/Lb light buses and exposes phase/status to a supervisory block and maintenance hold logic.

Parameters:
- TW, 5: timer width in bits.
- MIN_GREEN, 4: minimum green cycles per street.
- MAX_GREEN, 12: green cycles after which a waiting opposite street preempts.
- YEL_CYC, 3: yellow duration in cycles.
- ALLRED_CYC, 1: all-red clearance duration in cycles.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Ta  in  1  traffic present on street A.
- Tb  in  1  traffic present on street B.
- hold  in  1  maintenance freeze: timer and state frozen while high.
- La  out  2  street A light; GREEN=2'b00, YELLOW=2'b01, RED=2'b10.
- Lb  out  2  street B light, same encoding.
- phase  out  3  current state code.
- phase_chg  out  1  high during the first cycle of each newly entered state.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high.
- States and codes: A_GRN=0, A_YEL=1, AR_AB=2, B_GRN=3, B_YEL=4, AR_BA=5.
- Lights per state:
  - A_GRN: La=GREEN, Lb=RED.
  - A_YEL: La=YELLOW, Lb=RED.
  - B_GRN: La=RED, Lb=GREEN.
  - B_YEL: La=RED, Lb=YELLOW.
  - AR_AB, AR_BA: both RED.
- Outputs are Moore-decoded from the state register, so they change on the same edge as the state. No combinational path from inputs to outputs.
- Reset, applied immediately without waiting for a clock edge: state=A_GRN, timer=0, La=00, Lb=10, phase=0, phase_chg=0.
- Timer: cleared to 0 on entry to every state; increments by 1 each cycle the state is held and hold=0. It never exceeds MAX_GREEN-1; it saturates there in green.
- A_GRN -> A_YEL when timer>=MIN_GREEN-1 && Tb && (!Ta || timer>=MAX_GREEN-1).
  - Green therefore lasts at least MIN_GREEN cycles.
  - If Tb=0, A_GRN rests indefinitely.
- B_GRN -> B_YEL: same rule with Ta and Tb swapped.
- A_YEL -> AR_AB and B_YEL -> AR_BA when timer==YEL_CYC-1, giving exactly YEL_CYC cycles.
- AR_AB -> B_GRN and AR_BA -> A_GRN when timer==ALLRED_CYC-1, giving exactly ALLRED_CYC cycles.
- Sensors are sampled only at the decision edge. Pulses earlier in the green are not latched.
- hold=1: no state transition, timer frozen, phase_chg forced to 0 after the current cycle. Lights are unchanged. On release, counting resumes from the frozen value.
- hold and an exit condition on the same edge: hold wins.
- phase_chg: registered. Equals 1 exactly when the state changed on the previous edge.
- Illegal state codes 6 and 7: both lights RED; next state AR_BA. Recovery then proceeds to A_GRN.
- Elaboration checks:
  - MIN_GREEN>=1, MAX_GREEN>=MIN_GREEN, YEL_CYC>=1, ALLRED_CYC>=1.
  - All of them <= 2**TW - 1.

Decomposition:
- Package tl_sched_pkg holds:
  - light codes GREEN, YELLOW, RED;
  - the six state codes and the 3-bit state width.
- One sub-module, tl_phase_timer: TW-bit counter with clr, en (= !hold) and saturate-at-limit. The FSM drives clr on every transition.

Test Plan:
All scenarios use default parameters. Cycle 0 is the first edge after reset deasserts.
1. Ta=1, Tb=0 for 30 cycles -> La=00, Lb=10 throughout; phase=0; phase_chg never asserted.
2. Ta=0, Tb=1 constant -> A green cycles 0-3; A yellow 4-6; all-red 7; B green from cycle 8 and rests there; phase_chg high at cycles 4, 7, 8.
3. Ta=1, Tb=1 constant -> A green 12 cycles, yellow 3, all-red 1, B green 12, yellow 3, all-red 1; full cycle period is 32; both lights RED only in the all-red cycles.
4. Ta=0, Tb=1; assert hold at A_YEL timer=1 for 5 cycles -> La=01 for 8 cycles total; no phase_chg during hold; then AR_AB for 1 cycle.
5. Assert reset asynchronously mid B_GRN, between clock edges -> La=00, Lb=10, phase=0 before the next edge; after release, same sequence as scenario 2.
6. Ta=0; Tb pulses high at cycle 1 only, low afterwards -> no transition out of A_GRN. Then Tb=1 at cycle 9 -> A_YEL entered at cycle 10.
